// File: rtl/fifo_fsm_param.sv
// Single-port FIFO with FSM controller, busy/done handshake, occupancy flags and error reporting.
// Define FIFO_STICKY_ERR_EN to make overflow/underflow sticky until reset or ClearAllReg.
module fifo_fsm_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned AF_MARGIN  = 2,
  parameter int unsigned AE_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ClearAllReg,
  input  logic                  start,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  // Margins at or beyond DEPTH saturate so the flag is permanently asserted.
  localparam logic [ADDR_WIDTH:0] AF_LVL =
    (AF_MARGIN >= DEPTH) ? '0 : (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LVL =
    (AE_MARGIN >= DEPTH) ? FULL_LVL : (ADDR_WIDTH+1)'(AE_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     level_q, level_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  assign empty        = (level_q == '0);
  assign full         = (level_q == FULL_LVL);
  assign almost_empty = (level_q <= AE_LVL);
  assign almost_full  = (level_q >= AF_LVL);
  assign level        = level_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign data_out     = dout_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    mem_we   = 1'b0;
`ifdef FIFO_STICKY_ERR_EN
    ovf_d    = ovf_q;
    unf_d    = unf_q;
`else
    // Error flag set in WRITE/READ is visible only during the following DONE cycle.
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (write) begin
            state_d = S_WRITE;
            wdata_d = data_in;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        if (!full) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          level_d  = level_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_READ: begin
        if (!empty) begin
          dout_d   = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + 1'b1;
          level_d  = level_q - 1'b1;
        end else begin
          unf_d = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ClearAllReg) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      dout_d   = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_fifo_fsm_param.sv
// Self-checking bench for fifo_fsm_param: vector table, directed corner sequences, and random traffic vs a queue model.
module tb_fifo_fsm_param;

  localparam int DEPTH = 32;
  localparam int AFM   = 2;
  localparam int AEM   = 2;
`ifdef FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ClearAllReg, start, write;
  logic [7:0] data_in, data_out;
  logic       busy, done, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [5:0] level;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_ovf_st, m_unf_st;

  logic [7:0] o_d;
  logic       o_o, o_u;
  int         dones;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    logic [7:0] exp_dout;
    int         exp_lvl;
    bit         exp_unf;
  } vec_t;
  vec_t tbl[7];

  fifo_fsm_param #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(5),
    .AF_MARGIN (AFM),
    .AE_MARGIN (AEM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ClearAllReg (ClearAllReg),
    .start       (start),
    .write       (write),
    .data_in     (data_in),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .empty       (empty),
    .full        (full),
    .almost_empty(almost_empty),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_flags(input int lvl);
    chk("level", 32'(level), 32'(lvl));
    chk("empty", 32'(empty), 32'(lvl == 0));
    chk("full", 32'(full), 32'(lvl == DEPTH));
    chk("almost_empty", 32'(almost_empty), 32'(lvl <= AEM));
    chk("almost_full", 32'(almost_full), 32'(lvl >= DEPTH - AFM));
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout   = 8'h00;
    m_ovf_st = 1'b0;
    m_unf_st = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic run_txn(input bit wr, input logic [7:0] d,
                         output logic [7:0] rd, output logic ro, output logic ru);
    start   = 1'b1;
    write   = wr;
    data_in = d;
    @(negedge clk);
    start   = 1'b0;
    write   = 1'b0;
    data_in = 8'($urandom);
    chk("busy_in_op", 32'(busy), 32'd1);
    chk("done_in_op", 32'(done), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd1);
    rd = data_out;
    ro = overflow;
    ru = underflow;
    @(negedge clk);
    chk("done_cleared", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic model_txn(input bit wr, input logic [7:0] d);
    bit ev_o, ev_u;
    logic [7:0] rd;
    logic ro, ru;
    ev_o = 1'b0;
    ev_u = 1'b0;
    if (wr) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else ev_o = 1'b1;
    end else begin
      if (mq.size() > 0) m_dout = mq.pop_front();
      else ev_u = 1'b1;
    end
    m_ovf_st = m_ovf_st | ev_o;
    m_unf_st = m_unf_st | ev_u;
    run_txn(wr, d, rd, ro, ru);
    chk("data_out", 32'(rd), 32'(m_dout));
    chk("overflow_at_done", 32'(ro), 32'(STICKY ? m_ovf_st : ev_o));
    chk("underflow_at_done", 32'(ru), 32'(STICKY ? m_unf_st : ev_u));
    chk("overflow_idle", 32'(overflow), 32'(STICKY ? m_ovf_st : 1'b0));
    chk("underflow_idle", 32'(underflow), 32'(STICKY ? m_unf_st : 1'b0));
    check_flags(mq.size());
  endtask

  task automatic do_clear();
    ClearAllReg = 1'b1;
    @(negedge clk);
    ClearAllReg = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 8'h00, 1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 8'hA5, 0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 8'hA5, 0, 1'b1};
    tbl[3] = '{1'b1, 8'h3C, 8'hA5, 1, STICKY};
    tbl[4] = '{1'b1, 8'h7E, 8'hA5, 2, STICKY};
    tbl[5] = '{1'b0, 8'h00, 8'h3C, 1, STICKY};
    tbl[6] = '{1'b0, 8'h00, 8'h7E, 0, STICKY};

    rst_n = 1'b0; ClearAllReg = 1'b0; start = 1'b0; write = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_flags(0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_underflow", 32'(underflow), 32'd0);

    for (int k = 0; k < 7; k++) begin
      run_txn(tbl[k].wr, tbl[k].d, o_d, o_o, o_u);
      chk($sformatf("tbl%0d_dout", k), 32'(o_d), 32'(tbl[k].exp_dout));
      chk($sformatf("tbl%0d_unf", k), 32'(o_u), 32'(tbl[k].exp_unf));
      chk($sformatf("tbl%0d_ovf", k), 32'(o_o), 32'd0);
      chk($sformatf("tbl%0d_unf_idle", k), 32'(underflow), 32'(STICKY ? tbl[k].exp_unf : 1'b0));
      check_flags(tbl[k].exp_lvl);
    end
    do_clear();
    chk("clear_unf", 32'(underflow), 32'd0);
    chk("clear_dout", 32'(data_out), 32'd0);

    // Fill to full, overflow once, then drain across the pointer wrap.
    for (int i = 0; i < 29; i++) model_txn(1'b1, 8'(i));
    chk("af_at_29", 32'(almost_full), 32'd0);
    model_txn(1'b1, 8'd29);
    chk("af_at_30", 32'(almost_full), 32'd1);
    for (int i = 30; i < 32; i++) model_txn(1'b1, 8'(i));
    chk("full_at_32", 32'(full), 32'd1);
    model_txn(1'b1, 8'hEE);
    chk("level_after_ovf", 32'(level), 32'd32);
    for (int i = 0; i < 32; i++) begin
      model_txn(1'b0, 8'h00);
      chk("drain_order", 32'(data_out), 32'(i));
    end
    model_txn(1'b0, 8'h00);
    chk("underflow_keeps_dout", 32'(data_out), 32'h1F);
    do_clear();

    // start held through WRITE and DONE must not launch a second transaction.
    mq.push_back(8'h5A);
    dones   = 0;
    start   = 1'b1; write = 1'b1; data_in = 8'h5A;
    @(negedge clk);
    write   = 1'b0;
    if (done) dones++;
    @(negedge clk);
    if (done) dones++;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored", 32'(busy), 32'd0);
    repeat (5) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("one_done_per_start", 32'(dones), 32'd1);
    check_flags(mq.size());
    model_txn(1'b0, 8'h00);

    // ClearAllReg during WRITE aborts without a done pulse.
    model_txn(1'b1, 8'h11);
    start = 1'b1; write = 1'b1; data_in = 8'h22;
    @(negedge clk);
    start = 1'b0; write = 1'b0;
    ClearAllReg = 1'b1;
    @(negedge clk);
    ClearAllReg = 1'b0;
    model_reset();
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_dout", 32'(data_out), 32'd0);
    check_flags(0);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("clr_no_done", 32'(dones), 32'd0);

    // Asynchronous reset mid-cycle during READ.
    model_txn(1'b1, 8'hC3);
    model_txn(1'b1, 8'h99);
    model_txn(1'b0, 8'h00);
    start = 1'b1; write = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_dout", 32'(data_out), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_unf", 32'(underflow), 32'd0);
    check_flags(0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    model_txn(1'b1, 8'h42);
    model_txn(1'b0, 8'h00);

    // Random traffic in alternating write-heavy / read-heavy phases.
    do_clear();
    for (int i = 0; i < 320; i++) begin
      bit wr;
      if (((i / 64) % 2) == 0) wr = ($urandom_range(99) < 75);
      else                     wr = ($urandom_range(99) < 25);
      model_txn(wr, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
